// File: rtl/slice_sequencer.sv
// Slicing-head job controller: per slice, advance the feed stepper by the
// programmed thickness, then run one cut and wait for the driver's cut_end.
module slice_sequencer #(
    parameter int unsigned STEP_DIV     = 500000,
    parameter int unsigned STEPS_PER_MM = 5,
    parameter logic [39:0] CUT_TIMEOUT  = 40'd15_000_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [4:0] slice_num_i,
    input  logic [3:0] thick_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [4:0] slice_cnt_o,
    output logic       cut_o,
    input  logic       cut_end_i,
    output logic [3:0] feed_sig_o
);
    localparam int unsigned DIV_W  = $clog2(STEP_DIV);
    localparam int unsigned STEP_W = 16;
    localparam int unsigned TMO_W  = 40;
    localparam logic [3:0]  PHASE_RST = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_CUT,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [4:0]         slice_num_q, slice_num_d;
    logic [STEP_W-1:0]  target_q, target_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               gap_q, gap_d;
    logic [3:0]         phase_q, phase_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [4:0]         slice_cnt_q, slice_cnt_d;
    logic               cut_q, cut_d;
    logic [3:0]         feed_q, feed_d;

    logic               cut_edge;
    logic               div_tc;
    logic               tmo_hit;
    logic [STEP_W-1:0]  target_new;
    logic [STEP_W-1:0]  step_inc;

    assign cut_edge   = sync2_q & ~sync3_q;
    assign div_tc     = (div_q == DIV_W'(STEP_DIV - 1));
    assign tmo_hit    = (CUT_TIMEOUT != 40'd0) && (tmo_q == CUT_TIMEOUT - 40'd1);
    assign target_new = STEP_W'(32'(thick_i) * STEPS_PER_MM);
    assign step_inc   = step_q + STEP_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        slice_num_d = slice_num_q;
        target_d    = target_q;
        step_d      = step_q;
        div_d       = div_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        phase_d     = phase_q;
        err_d       = err_q;
        slice_cnt_d = slice_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    slice_num_d = slice_num_i;
                    target_d    = target_new;
                    slice_cnt_d = 5'd0;
                    err_d       = 1'b0;
                    step_d      = '0;
                    div_d       = '0;
                    tmo_d       = '0;
                    gap_d       = 1'b0;
                    if (slice_num_i == 5'd0) begin
                        state_d = ST_DONE;
                    end else if (target_new == '0) begin
                        state_d = ST_CUT;
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                div_d = div_q + DIV_W'(1);
                if (div_tc) begin
                    div_d   = '0;
                    phase_d = {phase_q[2:0], phase_q[3]};
                    step_d  = step_inc;
                    if (step_inc == target_q) begin
                        state_d = ST_CUT;
                        tmo_d   = '0;
                        gap_d   = 1'b0;
                    end
                end
            end
            ST_CUT: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                    tmo_d = '0;
                end else if (cut_edge) begin
                    slice_cnt_d = slice_cnt_q + 5'd1;
                    if (slice_cnt_d == slice_num_q) begin
                        state_d = ST_DONE;
                    end else if (target_q == '0) begin
                        // Zero thickness: drop cut_o for one cycle so the driver re-arms.
                        gap_d = 1'b1;
                        tmo_d = '0;
                    end else begin
                        state_d = ST_FEED;
                        step_d  = '0;
                        div_d   = '0;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, keeping the visible job status and motor phase.
        if (abort_i) begin
            state_d     = ST_IDLE;
            err_d       = err_q;
            slice_cnt_d = slice_cnt_q;
            phase_d     = phase_q;
            gap_d       = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        cut_d  = (state_d == ST_CUT) && !gap_d;
        feed_d = (state_d == ST_FEED) ? phase_d : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slice_num_q <= 5'd0;
            target_q    <= '0;
            step_q      <= '0;
            div_q       <= '0;
            tmo_q       <= '0;
            gap_q       <= 1'b0;
            phase_q     <= PHASE_RST;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            slice_cnt_q <= 5'd0;
            cut_q       <= 1'b0;
            feed_q      <= 4'b0000;
        end else begin
            state_q     <= state_d;
            slice_num_q <= slice_num_d;
            target_q    <= target_d;
            step_q      <= step_d;
            div_q       <= div_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            phase_q     <= phase_d;
            sync1_q     <= cut_end_i;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            slice_cnt_q <= slice_cnt_d;
            cut_q       <= cut_d;
            feed_q      <= feed_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign slice_cnt_o = slice_cnt_q;
    assign cut_o       = cut_q;
    assign feed_sig_o  = feed_q;

endmodule

// File: doc/slice_sequencer.md
# slice_sequencer

Job-level controller for the slicing head. It sits directly upstream of the cut driver. For each slice it first advances the food with the feed stepper by a programmable thickness, then drives `cut_o` into the cut driver's `cut_i` and waits for `cut_end` to return. It repeats this for the requested number of slices and then reports completion to the top-level FSM.

## Interface
- `STEP_DIV`, 500000: system clocks per feed step (10 ms at 50 MHz); must be ≥2.
- `STEPS_PER_MM`, 5: feed steps per mm of slice thickness.
- `CUT_TIMEOUT`, 40'd15_000_000_000: clocks allowed in CUT without a `cut_end` edge (300 s at 50 MHz); 0 disables the timeout.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  one-cycle job request; ignored while `busy_o`=1.
- `abort_i`  in  1  level; forces an immediate return to IDLE.
- `slice_num_i`  in  5  slices per job (0..31); latched on start.
- `thick_i`  in  4  slice thickness in mm (0..15); latched on start.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse at job completion.
- `err_o`  out  1  sticky cut-timeout flag; cleared by accepted start or reset.
- `slice_cnt_o`  out  5  slices completed in the current/last job.
- `cut_o`  out  1  to cut driver `cut_i`; high only in CUT.
- `cut_end_i`  in  1  from cut driver `cut_end_o`; slow-clock domain, asynchronous here.
- `feed_sig_o`  out  4  feed stepper coils (B' A' B A).

## Operation
- States: IDLE, FEED, CUT, DONE.
- IDLE, on `start_i`:
  - Latch `slice_num_i`/`thick_i`; clear `slice_cnt_o` and `err_o`.
  - Compute target = `thick` × `STEPS_PER_MM` into a 16-bit unsigned counter.
  - Next state: `slice_num`=0 → DONE; target=0 → CUT; otherwise FEED.
- FEED:
  - `feed_sig_o` = phase register.
  - The divider counts 0..`STEP_DIV`-1. At terminal count the phase advances 0011→0110→1100→1001→0011 and the step count increments.
  - When step count reaches the target, go to CUT. Step count and divider clear on each FEED entry.
- Phase register:
  - Resets to 0011.
  - Persists across slices and jobs, so the motor never skips a phase.
  - `feed_sig_o`=0000 outside FEED.
- CUT:
  - `cut_o`=1.
  - `cut_end_i` passes through a 2-flop synchronizer, then a rising-edge detect against the previous synchronized value. Only a rising edge counts; a level still high from the previous cut is ignored.
  - On an edge: `slice_cnt_o`+1. If the new count equals `slice_num`, go to DONE; otherwise go to FEED, or straight back to CUT for one cycle with `cut_o` low when target=0.
  - Timeout counter clears on CUT entry. When it reaches `CUT_TIMEOUT`-1 with no edge: `err_o`=1 and go to IDLE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `abort_i`=1 in any state: go to IDLE next cycle. No `done_o`; `err_o` and `slice_cnt_o` are unchanged.
- An edge arriving in the same cycle as the timeout: the edge wins (slice counted, no error).
- `abort_i` coinciding with `start_i` in IDLE: abort wins, start is dropped.

## Timing
- All outputs are registered. Reset values:
  - `busy_o`=0, `done_o`=0, `err_o`=0, `slice_cnt_o`=0, `cut_o`=0, `feed_sig_o`=0000.
  - State=IDLE, phase register=0011.
- `start_i` at edge k → `busy_o`=1 at k+1.
  - FEED: `feed_sig_o`=phase from k+1.
  - CUT (target=0): `cut_o`=1 from k+1.
  - DONE (`slice_num`=0): `done_o`=1 at k+1 and `busy_o`=0 at k+2.
- FEED lasts exactly target × `STEP_DIV` cycles; `cut_o` rises on the cycle after the last phase interval.
- `cut_end_i` rising before edge j → `cut_o`=0 and `slice_cnt_o` incremented after edge j+2 (sync 2 + detect).
- Two consecutive cuts (target=0) have ≥1 cycle with `cut_o`=0 between them, so the driver returns to its idle state.
- `abort_i` and timeout: all outputs reach IDLE values on the next cycle.
- Reset mid-operation clears everything immediately, including the synchronizer and phase.

## Test plan
Parameters for all scenarios: `STEP_DIV`=4, `STEPS_PER_MM`=2, `CUT_TIMEOUT`=100.
1. Two-slice job:
   - Stimulus: start with `slice_num`=2, `thick`=3; a cut_end model pulses `cut_end_i` 10 cycles after `cut_o` rises.
   - Required: first FEED gives `feed_sig_o` 0011,0110,1100,1001,0011,0110, 4 cycles each (24 cycles).
   - Required: second FEED starts at 1100.
   - Required: `slice_cnt_o` goes 1 then 2, then a single `done_o` pulse and `busy_o`=0.
2. `slice_num`=0 → `done_o` one cycle after start; `cut_o` and `feed_sig_o` never leave 0.
3. `thick`=0, `slice_num`=2 → `cut_o` high one cycle after start; ≥1 low cycle between the two cuts; `feed_sig_o` stays 0000.
4. No `cut_end_i` → exactly 100 cycles after `cut_o` rises: `err_o`=1, `cut_o`=0, `busy_o`=0, no `done_o`. Next start clears `err_o`.
5. `cut_end_i` held high from the previous cut at CUT entry → no slice counted until it falls and rises again.
6. Abort and reset:
   - Stimulus: `abort_i` mid-FEED. Required: next cycle `feed_sig_o`=0000, `busy_o`=0; a new start works.
   - Stimulus: `start_i` while busy. Required: ignored.
   - Stimulus: `rst_n` low mid-CUT. Required: `cut_o`=0 immediately.
